// File: rtl/csr_file_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_file_if
// Brief    : Writeback-stage bundle between the decoder and the CSR file.
//            It carries the strobes, the address, data and PC, and the IRQ
//            lines. It also carries the read data and the fetch redirect.
// Revision : 1.0 - initial release
// ============================================================================
interface csr_file_if;
    logic        valid;
    logic        csr_reg_wr;
    logic        csr_reg_rd;
    logic        is_mret;
    logic [11:0] csr_addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        timer_irq;
    logic        ext_irq;
    logic [31:0] rdata;
    logic        epc_taken;
    logic [31:0] epc;

    // Decoder / pipeline side
    modport master (
        output valid, csr_reg_wr, csr_reg_rd, is_mret, csr_addr, wdata, pc,
        output timer_irq, ext_irq,
        input  rdata, epc_taken, epc
    );

    // CSR file side
    modport slave (
        input  valid, csr_reg_wr, csr_reg_rd, is_mret, csr_addr, wdata, pc,
        input  timer_irq, ext_irq,
        output rdata, epc_taken, epc
    );
endinterface
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Brief    : Machine-mode CSR file. It handles timer and external interrupt
//            traps and the MRET return. Its outputs are a combinational read
//            port and a combinational fetch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    csr_file_if.slave   bus
);
    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] c_ADDR_MIE     = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] c_ADDR_MIP     = 12'h344;
    localparam logic [11:0] c_ADDR_MCYCLE  = 12'hB00;
    localparam logic [31:0] c_CAUSE_EXT    = 32'h8000_000B;
    localparam logic [31:0] c_CAUSE_TIMER  = 32'h8000_0007;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_mtie;
    logic        r_mie_meie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_mip_mtip;
    logic        r_mip_meip;
    logic [31:0] r_mcycle;

    logic        w_irq;
    logic        w_trap;
    logic        w_mret;
    logic        w_wr;
    logic [31:0] w_cause;
    logic [31:0] w_base;
    logic [31:0] w_vec_off;
    logic [31:0] w_rdata;
    logic [31:0] w_epc;

    // Interrupt enables come from registered state only, so an enable write
    // takes effect from the next cycle onward.
    assign w_irq     = bus.valid & r_mstatus_mie &
                       ((r_mip_meip & r_mie_meie) | (r_mip_mtip & r_mie_mtie));
    assign w_mret    = bus.is_mret & bus.valid;
    assign w_trap    = w_irq & ~bus.is_mret;
    assign w_wr      = bus.csr_reg_wr & bus.valid & ~w_trap;
    assign w_cause   = (r_mip_meip & r_mie_meie) ? c_CAUSE_EXT : c_CAUSE_TIMER;
    assign w_base    = {r_mtvec[31:2], 2'b00};
    assign w_vec_off = {26'd0, w_cause[3:0], 2'b00};

    // Read mux. A bubble or a missing read strobe gives 0.
    always_comb begin
        w_rdata = 32'd0;
        if (bus.csr_reg_rd && bus.valid) begin
            case (bus.csr_addr)
                c_ADDR_MSTATUS: w_rdata = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
                c_ADDR_MIE:     w_rdata = {20'd0, r_mie_meie, 3'd0, r_mie_mtie, 7'd0};
                c_ADDR_MTVEC:   w_rdata = r_mtvec;
                c_ADDR_MEPC:    w_rdata = r_mepc;
                c_ADDR_MCAUSE:  w_rdata = r_mcause;
                c_ADDR_MIP:     w_rdata = {20'd0, r_mip_meip, 3'd0, r_mip_mtip, 7'd0};
                c_ADDR_MCYCLE:  w_rdata = r_mcycle;
                default:        w_rdata = 32'd0;
            endcase
        end
    end

    // Redirect target. MRET wins over a trap, and vectored mode adds 4*cause.
    always_comb begin
        w_epc = 32'd0;
        if (w_mret) begin
            w_epc = r_mepc;
        end else if (w_trap) begin
            w_epc = (r_mtvec[1:0] == 2'b01) ? (w_base + w_vec_off) : w_base;
        end
    end

    assign bus.rdata     = w_rdata;
    assign bus.epc       = w_epc;
    assign bus.epc_taken = w_trap | w_mret;

    // The cycle counter and the interrupt pins update even during bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle   <= 32'd0;
            r_mip_mtip <= 1'b0;
            r_mip_meip <= 1'b0;
        end else begin
            r_mip_mtip <= bus.timer_irq;
            r_mip_meip <= bus.ext_irq;
            if (w_wr && (bus.csr_addr == c_ADDR_MCYCLE)) begin
                r_mcycle <= bus.wdata;
            end else begin
                r_mcycle <= r_mcycle + 32'd1;
            end
        end
    end

    // Architectural CSR state. Trap and MRET updates are placed after the
    // write decode. A trap already suppresses the write. For MRET, its
    // mstatus update wins over a CSR write in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mtvec        <= MTVEC_RST;
            r_mepc         <= 32'd0;
            r_mcause       <= 32'd0;
        end else begin
            if (w_wr) begin
                case (bus.csr_addr)
                    c_ADDR_MSTATUS: begin
                        r_mstatus_mie  <= bus.wdata[3];
                        r_mstatus_mpie <= bus.wdata[7];
                    end
                    c_ADDR_MIE: begin
                        r_mie_mtie <= bus.wdata[7];
                        r_mie_meie <= bus.wdata[11];
                    end
                    c_ADDR_MTVEC:  r_mtvec  <= bus.wdata;
                    c_ADDR_MEPC:   r_mepc   <= {bus.wdata[31:2], 2'b00};
                    c_ADDR_MCAUSE: r_mcause <= bus.wdata;
                    default: ;
                endcase
            end
            if (w_trap) begin
                r_mepc         <= bus.pc;
                r_mcause       <= w_cause;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (w_mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Brief    : Self-checking bench for csr_file. It runs directed scenarios and
//            then random traffic. All of it is compared against a
//            word-level architectural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;
    localparam logic [31:0] c_MTVEC_RST = 32'h0000_0100;

    logic clk;
    logic rst_n;
    csr_file_if bus_if();

    csr_file #(.MTVEC_RST(c_MTVEC_RST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Architectural model: whole CSR words
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip, m_mcycle;
    logic [31:0] exp_rdata, exp_epc;
    logic        exp_taken;

    task automatic mdl_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = c_MTVEC_RST; m_mepc = 0;
        m_mcause = 0; m_mip = 0; m_mcycle = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_mcycle;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_irq();
        return bus_if.valid && m_mstatus[3] && ((m_mip & m_mie) != 0);
    endfunction

    function automatic logic [31:0] m_cause();
        return (m_mip[11] && m_mie[11]) ? 32'h8000_000B : 32'h8000_0007;
    endfunction

    task automatic mdl_outputs();
        bit mret, trap;
        logic [31:0] base, cause;
        mret  = bus_if.valid && bus_if.is_mret;
        trap  = m_irq() && !bus_if.is_mret;
        cause = m_cause();
        base  = m_mtvec & 32'hFFFF_FFFC;
        exp_rdata = (bus_if.valid && bus_if.csr_reg_rd) ? m_read(bus_if.csr_addr) : 32'd0;
        exp_taken = trap || mret;
        if (mret)      exp_epc = m_mepc;
        else if (trap) exp_epc = (m_mtvec % 4 == 1) ? base + 4 * (cause % 16) : base;
        else           exp_epc = 32'd0;
    endtask

    // Drive one cycle's inputs shortly after the falling edge, then compute the model's outputs.
    task automatic set_in(input bit v, wr, rd, mr, input logic [11:0] a,
                          input logic [31:0] wd, p, input bit t, e);
        bus_if.valid = v; bus_if.csr_reg_wr = wr; bus_if.csr_reg_rd = rd;
        bus_if.is_mret = mr; bus_if.csr_addr = a; bus_if.wdata = wd;
        bus_if.pc = p; bus_if.timer_irq = t; bus_if.ext_irq = e;
        #1;
        mdl_outputs();
    endtask

    // Advance one rising edge and apply the architectural state update.
    task automatic tick();
        bit mret, trap, wr;
        logic [31:0] cause, old_ms;
        @(posedge clk);
        mret   = bus_if.valid && bus_if.is_mret;
        trap   = m_irq() && !bus_if.is_mret;
        wr     = bus_if.valid && bus_if.csr_reg_wr && !trap;
        cause  = m_cause();
        old_ms = m_mstatus;
        m_mcycle = m_mcycle + 1;
        if (wr) begin
            case (bus_if.csr_addr)
                12'h300: m_mstatus = bus_if.wdata & 32'h0000_0088;
                12'h304: m_mie     = bus_if.wdata & 32'h0000_0880;
                12'h305: m_mtvec   = bus_if.wdata;
                12'h341: m_mepc    = bus_if.wdata & 32'hFFFF_FFFC;
                12'h342: m_mcause  = bus_if.wdata;
                12'hB00: m_mcycle  = bus_if.wdata;
                default: ;
            endcase
        end
        if (trap) begin
            m_mepc = bus_if.pc; m_mcause = cause;
            m_mstatus = old_ms[3] ? 32'h80 : 32'h0;
        end else if (mret) begin
            m_mstatus = 32'h80 | (old_ms[7] ? 32'h8 : 32'h0);
        end
        m_mip = (bus_if.timer_irq ? 32'h80 : 32'h0) | (bus_if.ext_irq ? 32'h800 : 32'h0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 12'h0, 0, 0, 0, 0);
        mdl_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [8];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB00, 12'h7C0};
        @(negedge clk);
        rst_n = 1'b0;
        set_in(1, 0, 1, 0, 12'hB00, 0, 0, 0, 0);
        checks++;
        if (bus_if.rdata !== 32'd0 || bus_if.epc_taken !== 1'b0 || bus_if.epc !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: rdata=%h taken=%b epc=%h, want all 0",
                     bus_if.rdata, bus_if.epc_taken, bus_if.epc);
        end
        do_reset();
        foreach (addrs[i]) begin
            set_in(1, 0, 1, 0, addrs[i], 0, 32'h10, 0, 0);
            checks++;
            if (bus_if.rdata !== exp_rdata) begin
                failures++;
                $display("FAIL reset_read[%h]: got %h want %h", addrs[i], bus_if.rdata, exp_rdata);
            end
            if (addrs[i] == 12'h305) begin
                checks++;
                if (bus_if.rdata !== c_MTVEC_RST) begin
                    failures++;
                    $display("FAIL reset_mtvec: got %h want %h", bus_if.rdata, c_MTVEC_RST);
                end
            end
            tick();
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0, 12'h0, 0, 0, 0, 0);
            checks++;
            if (bus_if.epc_taken !== 1'b0) begin
                failures++;
                $display("FAIL idle_taken cyc%0d: got %b want 0", i, bus_if.epc_taken);
            end
            tick();
        end
        set_in(1, 0, 1, 0, 12'hB00, 0, 32'h20, 0, 0);
        checks++;
        if (bus_if.rdata !== 32'd5 || exp_rdata !== 32'd5) begin
            failures++;
            $display("FAIL idle_mcycle: got %h model %h want 5", bus_if.rdata, exp_rdata);
        end
        tick();
        set_in(1, 0, 1, 0, 12'h300, 0, 32'h24, 0, 0);
        checks++;
        if (bus_if.rdata !== 32'd0) begin
            failures++;
            $display("FAIL idle_mstatus: got %h want 0", bus_if.rdata);
        end
        tick();
    endtask

    task automatic test_timer_trap();
        set_in(1, 1, 0, 0, 12'h300, 32'h8, 32'h30, 0, 0); tick();
        set_in(1, 1, 0, 0, 12'h304, 32'h80, 32'h34, 0, 0); tick();
        set_in(1, 0, 0, 0, 12'h0, 0, 32'h40, 1, 0);
        checks++;
        if (bus_if.epc_taken !== 1'b0) begin
            failures++;
            $display("FAIL timer_early: taken=%b want 0", bus_if.epc_taken);
        end
        tick();
        set_in(1, 0, 0, 0, 12'h0, 0, 32'h44, 1, 0);
        checks++;
        if (bus_if.epc_taken !== 1'b1 || bus_if.epc !== c_MTVEC_RST || exp_epc !== c_MTVEC_RST) begin
            failures++;
            $display("FAIL timer_trap: taken=%b epc=%h want 1/%h", bus_if.epc_taken, bus_if.epc, c_MTVEC_RST);
        end
        tick();
        set_in(1, 0, 1, 0, 12'h342, 0, 32'h100, 0, 0);
        checks++;
        if (bus_if.rdata !== 32'h8000_0007) begin
            failures++;
            $display("FAIL timer_mcause: got %h want 80000007", bus_if.rdata);
        end
        tick();
        set_in(1, 0, 1, 0, 12'h341, 0, 32'h104, 0, 0);
        checks++;
        if (bus_if.rdata !== 32'h44) begin
            failures++;
            $display("FAIL timer_mepc: got %h want 44", bus_if.rdata);
        end
        tick();
        set_in(1, 0, 1, 0, 12'h300, 0, 32'h108, 0, 0);
        checks++;
        if (bus_if.rdata !== 32'h80) begin
            failures++;
            $display("FAIL timer_mstatus: got %h want 80", bus_if.rdata);
        end
        tick();
    endtask

    task automatic test_vectored();
        set_in(1, 1, 0, 0, 12'h305, 32'h1001, 32'h110, 0, 0); tick();
        set_in(1, 1, 0, 0, 12'h304, 32'h880, 32'h114, 0, 0); tick();
        set_in(1, 1, 0, 0, 12'h300, 32'h8, 32'h118, 0, 0); tick();
        set_in(0, 0, 0, 0, 12'h0, 0, 0, 1, 1); tick();
        set_in(1, 0, 0, 0, 12'h0, 0, 32'h200, 1, 1);
        checks++;
        if (bus_if.epc_taken !== 1'b1 || bus_if.epc !== 32'h102C || exp_epc !== 32'h102C) begin
            failures++;
            $display("FAIL vectored_epc: taken=%b epc=%h want 1/0000102c", bus_if.epc_taken, bus_if.epc);
        end
        tick();
        set_in(1, 0, 1, 0, 12'h342, 0, 32'h204, 0, 0);
        checks++;
        if (bus_if.rdata !== 32'h8000_000B) begin
            failures++;
            $display("FAIL vectored_mcause: got %h want 8000000b", bus_if.rdata);
        end
        tick();
    endtask

    task automatic test_mret();
        set_in(1, 1, 0, 0, 12'h341, 32'h3002, 32'h210, 0, 0); tick();
        set_in(1, 0, 0, 1, 12'h0, 0, 32'h214, 0, 0);
        checks++;
        if (bus_if.epc_taken !== 1'b1 || bus_if.epc !== 32'h3000) begin
            failures++;
            $display("FAIL mret_epc: taken=%b epc=%h want 1/00003000", bus_if.epc_taken, bus_if.epc);
        end
        tick();
        set_in(1, 0, 1, 0, 12'h300, 0, 32'h3000, 0, 0);
        checks++;
        if (bus_if.rdata !== 32'h88 || bus_if.epc_taken !== 1'b0) begin
            failures++;
            $display("FAIL mret_mstatus: got %h taken=%b want 88/0", bus_if.rdata, bus_if.epc_taken);
        end
        tick();
    endtask

    task automatic test_mret_priority();
        set_in(0, 0, 0, 0, 12'h0, 0, 0, 1, 0); tick();
        set_in(1, 0, 0, 1, 12'h0, 0, 32'h500, 1, 0);
        checks++;
        if (bus_if.epc_taken !== 1'b1 || bus_if.epc !== 32'h3000) begin
            failures++;
            $display("FAIL mret_prio_redirect: taken=%b epc=%h want 1/00003000", bus_if.epc_taken, bus_if.epc);
        end
        tick();
        set_in(1, 0, 0, 0, 12'h0, 0, 32'h504, 1, 0);
        checks++;
        if (bus_if.epc_taken !== 1'b1 || bus_if.epc !== 32'h101C) begin
            failures++;
            $display("FAIL mret_prio_trap: taken=%b epc=%h want 1/0000101c", bus_if.epc_taken, bus_if.epc);
        end
        tick();
        set_in(1, 0, 1, 0, 12'h341, 0, 32'h508, 1, 0);
        checks++;
        if (bus_if.rdata !== 32'h504) begin
            failures++;
            $display("FAIL mret_prio_mepc: got %h want 504", bus_if.rdata);
        end
        tick();
    endtask

    task automatic test_trap_write();
        set_in(1, 0, 0, 1, 12'h0, 0, 32'h600, 1, 0); tick();
        set_in(1, 1, 0, 0, 12'h305, 32'hDEAD_BEEC, 32'h504, 1, 0);
        checks++;
        if (bus_if.epc_taken !== 1'b1) begin
            failures++;
            $display("FAIL trap_write_taken: got %b want 1", bus_if.epc_taken);
        end
        tick();
        set_in(1, 0, 1, 0, 12'h305, 0, 32'h1010, 0, 0);
        checks++;
        if (bus_if.rdata !== 32'h1001) begin
            failures++;
            $display("FAIL trap_write_mtvec: got %h want 00001001", bus_if.rdata);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        set_in(0, 0, 0, 0, 12'h0, 0, 0, 0, 0); tick();
        set_in(1, 1, 0, 0, 12'h300, 32'h8, 32'h700, 0, 0); tick();
        set_in(1, 1, 0, 0, 12'h304, 32'h80, 32'h704, 0, 0); tick();
        set_in(0, 0, 0, 0, 12'h0, 0, 0, 1, 0); tick();
        set_in(1, 0, 1, 0, 12'hB00, 0, 32'h708, 1, 0);
        checks++;
        if (bus_if.epc_taken !== 1'b1 || bus_if.rdata !== exp_rdata) begin
            failures++;
            $display("FAIL midrst_before: taken=%b rdata=%h want 1/%h", bus_if.epc_taken, bus_if.rdata, exp_rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.rdata !== 32'd0 || bus_if.epc_taken !== 1'b0 || bus_if.epc !== 32'd0) begin
            failures++;
            $display("FAIL midrst_outputs: rdata=%h taken=%b epc=%h want all 0",
                     bus_if.rdata, bus_if.epc_taken, bus_if.epc);
        end
        mdl_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 12'h0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 0, 1, 0, 12'h341, 0, 32'h800, 0, 0);
        checks++;
        if (bus_if.rdata !== 32'd0) begin
            failures++;
            $display("FAIL midrst_mepc: got %h want 0", bus_if.rdata);
        end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] addrs [9];
        bit t, e;
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB00, 12'h123, 12'h300};
        t = 0; e = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) t = ~t;
            if ($urandom_range(0, 6) == 0) e = ~e;
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                   addrs[$urandom_range(0, 8)], $urandom(), $urandom(), t, e);
            checks++;
            if (bus_if.rdata !== exp_rdata || bus_if.epc_taken !== exp_taken || bus_if.epc !== exp_epc) begin
                failures++;
                $display("FAIL random cyc%0d: rdata=%h taken=%b epc=%h want %h/%b/%h",
                         i, bus_if.rdata, bus_if.epc_taken, bus_if.epc, exp_rdata, exp_taken, exp_epc);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_idle();
        test_timer_trap();
        test_vectored();
        test_mret();
        test_mret_priority();
        test_trap_write();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/csr_file.md
# csr_file

Machine-mode control-and-status register file with interrupt and trap-return handling. It sits in the writeback stage of the 3-stage pipeline, directly downstream of the instruction decoder. It consumes the decoder's CSR write, CSR read and MRET strobes. On a trap or return it redirects the fetch PC through `epc_taken`/`epc`.

## Interface
Parameters:
- `MTVEC_RST`, 32'h0000_0000: reset value of mtvec.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `valid` in 1: writeback slot holds a real instruction (0 = bubble).
- `csr_reg_wr` in 1: CSRRW write strobe from the decoder.
- `csr_reg_rd` in 1: CSR read strobe from the decoder.
- `is_mret` in 1: MRET strobe from the decoder.
- `csr_addr` in 12: CSR address (instruction[31:20]).
- `wdata` in 32: CSR write data (rs1 value).
- `pc` in 32: PC of the instruction in writeback.
- `timer_irq` in 1: timer interrupt line, level.
- `ext_irq` in 1: external interrupt line, level.
- `rdata` out 32: CSR read data to the writeback mux.
- `epc_taken` out 1: redirect fetch this cycle.
- `epc` out 32: redirect target.

## Operation
- Implemented CSRs. All are 32-bit. Unimplemented addresses read 0 and ignore writes.
  - mstatus 0x300: only MIE[3] and MPIE[7] are storage; other bits read 0.
  - mie 0x304: only MTIE[7] and MEIE[11] are storage.
  - mtvec 0x305: full 32 bits; mode in [1:0].
  - mepc 0x341: bits [1:0] are forced to 0 on every write.
  - mcause 0x342: full 32 bits.
  - mip 0x344: read-only. MTIP[7] and MEIP[11] are registered copies of `timer_irq` and `ext_irq`.
  - mcycle 0xB00: free-running counter, incremented every cycle, wraps 0xFFFF_FFFF to 0.
- Reads: `rdata` is the selected CSR when `csr_reg_rd`&`valid`, else 0. It is combinational, so a same-cycle write is not visible.
- Writes: on `csr_reg_wr`&`valid`&!trap, the addressed CSR takes `wdata` at the clock edge. A write to mcycle overrides that cycle's increment.
- Interrupt condition: `irq = valid & mstatus.MIE & ((mip.MEIP & mie.MEIE) | (mip.MTIP & mie.MTIE))`.
- `trap = irq & !is_mret`. MRET has priority; the interrupt is re-evaluated the next cycle once MIE is restored.
- Cause on trap: external (32'h8000_000B) has priority over timer (32'h8000_0007).
- Trap actions:
  - mepc <= pc.
  - mcause <= cause.
  - MPIE <= MIE; MIE <= 0.
  - The instruction's CSR write is suppressed; the instruction re-executes after MRET.
- MRET actions (when `is_mret`&`valid`): MIE <= MPIE; MPIE <= 1.
- Outputs:
  - `epc_taken = trap | (is_mret & valid)`.
  - On MRET, `epc` = mepc.
  - On trap with mtvec[1:0]==1 (vectored), `epc` = {mtvec[31:2],2'b00} + 4×cause[3:0].
  - On trap otherwise, `epc` = {mtvec[31:2],2'b00}.
  - With no redirect, `epc` = 0.
- Bubbles (`valid`=0) never read, write, trap or return. mcycle and mip still update.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - All CSRs = 0, except mtvec = `MTVEC_RST`.
  - mip = 0, mcycle = 0.
  - `rdata`, `epc_taken`, `epc` = 0.
- Reset mid-operation aborts any pending trap. The state is unconditionally reinitialised.
- `rdata`, `epc_taken` and `epc` are combinational in the same cycle as the strobes, with 0 cycles of latency. All state updates happen at the next rising edge.
- IRQ latency: pin high at edge N, mip set after edge N, trap can be taken in cycle N+1 at the earliest.
- A CSR write to mstatus/mie in cycle N affects `irq` from cycle N+1.
- A write to mepc followed by MRET in the next cycle redirects to the new value.
- mcycle reads the value held before the current edge. After a write of W in cycle N, a read in cycle N+1 returns W, and a read in N+2 returns W+1.

## Test plan
- Reset then idle 5 cycles -> read 0xB00 returns 5. `epc_taken` stays 0 throughout. mstatus reads 0.
- Write 0x300=0x8 and 0x304=0x80, then raise `timer_irq` at cycle 10 -> `epc_taken`=1 at cycle 11 with `epc`=mtvec base. mcause=0x8000_0007, mepc=pc@11, mstatus reads 0x80.
- mtvec=0x1001 (vectored), MEIE+MTIE enabled, both irqs high -> `epc`=0x1000+44=0x102C and mcause=0x8000_000B.
- After a trap, issue MRET with `valid` -> `epc_taken`=1 and `epc`=saved mepc. mstatus reads 0x88 the next cycle.
- MRET and a pending interrupt in the same cycle -> MRET redirect only. The trap fires the following cycle with mepc = that cycle's pc.
- Trap coincident with `csr_reg_wr` to 0x305=0xDEAD_BEEC -> mtvec is unchanged. Pulse `rst_n` low mid-cycle -> all outputs return to 0 immediately.
